timer_irq_src: RTL

- Memory-mapped countdown timer that drives one HWInt line into the CP0 interrupt input. It is the interrupt-source end of the HWInt/IntReq path.
- The CPU reaches it through the system bridge with word-addressed loads and stores.
- It counts down from a software-loaded preset and raises IRQ on expiry. Two modes: one-shot (IRQ level held until software acknowledges) and auto-reload (one-cycle IRQ pulse per period).

---
 rtl/timer_irq_src_if.sv | 11 +
 rtl/timer_irq_src.sv | 125 ++++++++++++
 2 files changed

// File: rtl/timer_irq_src_if.sv
// Bridge-side word bus into the timer plus its single interrupt request line.
interface timer_irq_src_if;
  logic [1:0]  Addr;
  logic        We;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, We, Din, input Dout, IRQ);
  modport slave  (input Addr, We, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_irq_src.sv
// Countdown timer feeding one CP0 HWInt line: one-shot (held IRQ until ack)
// or auto-reload (one-cycle IRQ pulse per period).
module timer_irq_src #(
  parameter int unsigned CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  timer_irq_src_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             irq_pend_q, irq_pend_d;

  logic wr_ctrl;
  logic wr_preset;
  logic en;
  logic auto_mode;

  assign wr_ctrl   = bus.We && (bus.Addr == 2'd0);
  assign wr_preset = bus.We && (bus.Addr == 2'd1);
  assign en        = ctrl_q[0];
  assign auto_mode = (ctrl_q[2:1] == 2'b01);

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_pend_d = irq_pend_q;

    // Acknowledge first so that an expiry on the same edge overrides it.
    if (wr_ctrl || wr_preset) begin
      irq_pend_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (count_q > ONE) begin
          count_d = count_q - ONE;
        end else begin
          count_d    = '0;
          irq_pend_d = 1'b1;
          state_d    = S_INT;
        end
      end
      S_INT: begin
        if (!en) begin
          state_d = S_IDLE;
          if (auto_mode) begin
            irq_pend_d = 1'b0;
          end
        end else if (auto_mode) begin
          irq_pend_d = 1'b0;
          state_d    = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // CPU stores land last so a CTRL write beats the one-shot EN clear.
    if (wr_ctrl) begin
      ctrl_d = bus.Din[3:0];
    end
    if (wr_preset) begin
      preset_d = bus.Din[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  always_comb begin
    bus.Dout = '0;
    case (bus.Addr)
      2'd0:    bus.Dout = {28'd0, ctrl_q};
      2'd1:    bus.Dout = 32'(preset_q);
      2'd2:    bus.Dout = 32'(count_q);
      default: bus.Dout = '0;
    endcase
  end

  assign bus.IRQ = irq_pend_q & ctrl_q[3];

endmodule
